mem_word_seq: RTL and testbench

MEM_WORD_SEQ -- requirements
Module: mem_word_seq

---
 rtl/mem_seq_pkg.sv | 22 ++
 rtl/mem_seq_bitcnt.sv | 40 ++++
 rtl/mem_word_seq.sv | 118 +++++++++++
 tb/tb_mem_word_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared defaults and FSM state encoding for the bit-serial
// memory word sequencer (mem_word_seq and its bit counter).
package mem_seq_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;
  localparam int SEL_W_DEF  = 2;

  // Encodings match the legacy two-bit state constants.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RSP  = 2'b11
  } state_t;

  // Counter width for a WORD_W-bit transfer; at least one bit.
  function automatic int cnt_width(input int word_w);
    return (word_w > 1) ? $clog2(word_w) : 1;
  endfunction

endpackage

// File: rtl/mem_seq_bitcnt.sv
// mem_seq_bitcnt: per-transfer bit counter k (0..WORD_W-1) and the wrapped
// bit address base + k (mod 2^ADDR_W).
// Ports:
//   clk, rst  - clock, synchronous active-low reset
//   run       - high while a transfer is shifting bits
//   base      - latched base bit address
//   k         - current bit index
//   last      - k is the final bit of the word
//   addr      - (base + k) truncated to ADDR_W bits
module mem_seq_bitcnt #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 10,
  parameter int K_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W-1:0] base,
  output logic [K_W-1:0]    k,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      k <= '0;
    end else if (run && !last) begin
      k <= k + 1'b1;
    end else begin
      k <= '0;
    end
  end

  always_comb begin
    last = (k == K_W'(WORD_W - 1));
    // Truncation to ADDR_W bits gives the silent wrap past the top address.
    addr = base + ADDR_W'(k);
  end

endmodule

// File: rtl/mem_word_seq.sv
// mem_word_seq: accepts one word read/write request and serialises it into
// WORD_W single-bit memory accesses (LSB first) at consecutive bit addresses.
// Reads return the assembled word on a valid/ready response port.
// Ports:
//   clk, rst                       - clock, synchronous active-low reset
//   req_valid/req_ready            - request handshake
//   req_write/bank/addr/wdata      - request direction, bank, base address, word
//   rsp_valid/rsp_ready/rsp_data   - response handshake and read word
//   busy                           - any state other than IDLE
//   mem_sel/read_rq/write_rq/addr/wdata/rdata - bit-serial memory interface
// Configuration macro:
//   MEM_SEQ_WRITE_ACK_EN - when defined, writes also produce a response
//                          carrying the written word.
module mem_word_seq
  import mem_seq_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [SEL_W-1:0]  req_bank,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_data,
  output logic              busy,
  output logic [SEL_W-1:0]  mem_sel,
  output logic              mem_read_rq,
  output logic              mem_write_rq,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wdata,
  input  logic              mem_rdata
);

  localparam int K_W = cnt_width(WORD_W);

  state_t            state;
  logic [SEL_W-1:0]  bank_q;
  logic [ADDR_W-1:0] base_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;

  logic              run;
  logic [K_W-1:0]    k;
  logic              last;
  logic [ADDR_W-1:0] bit_addr;

  mem_seq_bitcnt #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W),
    .K_W    (K_W)
  ) u_bitcnt (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .base (base_q),
    .k    (k),
    .last (last),
    .addr (bit_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      bank_q  <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            bank_q  <= req_bank;
            base_q  <= req_addr;
            wdata_q <= req_wdata;
            state   <= req_write ? WR : RD;
          end
        end
        RD: begin
          rdata_q[k] <= mem_rdata;
          if (last) state <= RSP;
        end
        WR: begin
`ifdef MEM_SEQ_WRITE_ACK_EN
          rdata_q[k] <= wdata_q[k];
          if (last) state <= RSP;
`else
          if (last) state <= IDLE;
`endif
        end
        RSP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    run          = (state == RD) || (state == WR);
    req_ready    = (state == IDLE);
    busy         = (state != IDLE);
    rsp_valid    = (state == RSP);
    rsp_data     = rdata_q;
    mem_read_rq  = (state == RD);
    mem_write_rq = (state == WR);
    mem_sel      = busy ? bank_q : '0;
    mem_addr     = run ? bit_addr : '0;
    mem_wdata    = (state == WR) ? wdata_q[k] : 1'b0;
  end

endmodule

// File: tb/tb_mem_word_seq.sv
// tb_mem_word_seq: directed scoreboard bench for mem_word_seq with a
// bit-addressed memory model on the DUT side and a separate reference image
// used to form expected read words.
module tb_mem_word_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_bank;
  logic [9:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;
  logic [1:0] mem_sel;
  logic       mem_read_rq;
  logic       mem_write_rq;
  logic [9:0] mem_addr;
  logic       mem_wdata;
  logic       mem_rdata;

  mem_word_seq #(
    .WORD_W (8),
    .ADDR_W (10),
    .SEL_W  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_bank     (req_bank),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .mem_sel      (mem_sel),
    .mem_read_rq  (mem_read_rq),
    .mem_write_rq (mem_write_rq),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int acc_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory seen by the DUT and reference image maintained by the bench.
  bit env_mem [4][1024];
  bit ref_mem [4][1024];

  assign mem_rdata = env_mem[mem_sel][mem_addr];
  always @(posedge clk) if (mem_write_rq) env_mem[mem_sel][mem_addr] <= mem_wdata;

  typedef struct packed {
    logic [1:0] sel;
    logic [9:0] addr;
    logic       b;
  } acc_t;

  acc_t       wr_log[$];
  acc_t       rd_log[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_word(input logic [1:0] b, input logic [9:0] a);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[i] = ref_mem[b][a + 10'(i)];
    return w;
  endfunction

  // Monitor: scoreboard pops on response handshake, interface invariants.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (mem_write_rq) wr_log.push_back('{mem_sel, mem_addr, mem_wdata});
      if (mem_read_rq)  rd_log.push_back('{mem_sel, mem_addr, mem_rdata});
      chk("strobe_overlap", {31'd0, mem_read_rq & mem_write_rq}, 32'd0);
      if (!busy) chk("idle_outputs", {27'd0, mem_sel, mem_read_rq, mem_write_rq, |mem_addr}, 32'd0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst !== 1'b1) !(mem_read_rq && mem_write_rq))
    else $error("FAIL strobe_overlap_assert");

  task automatic send(input bit wr, input logic [1:0] b, input logic [9:0] a, input logic [7:0] d);
    bit ok = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_bank = b; req_addr = a; req_wdata = d;
    for (int i = 0; i < 100; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("req_accept", {31'd0, ok}, 32'd1);
    if (wr) begin
      for (int i = 0; i < 8; i++) ref_mem[b][a + 10'(i)] = d[i];
`ifdef MEM_SEQ_WRITE_ACK_EN
      exp_q.push_back(d);
`endif
    end else begin
      exp_q.push_back(ref_word(b, a));
    end
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    // Junk on the request bus must not disturb the transfer.
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_bank  = 2'($urandom);
    req_addr  = 10'($urandom);
    req_wdata = 8'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    chk("wait_idle", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    int         lat;
    int         a0;
    bit         ok;

    rst = 1'b0; rsp_ready = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_bank = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data",  {24'd0, rsp_data}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_mem", {19'd0, mem_sel, mem_read_rq, mem_write_rq, mem_addr}, 32'd0);
    chk("rst_wdata",     {31'd0, mem_wdata}, 32'd0);
    rst = 1'b1;

    // Write 0xA5 to bank 1 at 0x010: eight LSB-first write strobes.
    wr_log.delete();
    send(1'b1, 2'd1, 10'h010, 8'hA5);
    wait_idle();
    chk("wr_count", wr_log.size(), 32'd8);
    for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
      chk("wr_addr", {22'd0, wr_log[i].addr}, 32'h010 + i);
      chk("wr_sel",  {30'd0, wr_log[i].sel}, 32'd1);
      chk("wr_bit",  {31'd0, wr_log[i].b}, {31'd0, 1'(8'hA5 >> i)});
    end

    // Read it back; response in the 9th cycle after the accept edge.
    send(1'b0, 2'd1, 10'h010, 8'h00);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = i; break; end
    end
    chk("rd_latency", lat, 32'd9);
    chk("rd_data_A5", {24'd0, rsp_data}, 32'h0A5);
    wait_idle();

    // Wrap: write then read bank 2 at 0x3FC.
    send(1'b1, 2'd2, 10'h3FC, 8'h96);
    wait_idle();
    rd_log.delete();
    send(1'b0, 2'd2, 10'h3FC, 8'h00);
    wait_idle();
    chk("rd_count", rd_log.size(), 32'd8);
    for (int i = 0; i < 8 && i < rd_log.size(); i++)
      chk("rd_wrap_addr", {22'd0, rd_log[i].addr}, (32'h3FC + i) & 32'h3FF);

    // Response held for 5 cycles with rsp_ready low.
    rsp_ready = 1'b0;
    send(1'b0, 2'd1, 10'h010, 8'h00);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    chk("hold_rsp_seen", {31'd0, ok}, 32'd1);
    held = rsp_data;
    chk("hold_data_value", {24'd0, held}, 32'h0A5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_data",  {24'd0, rsp_data}, {24'd0, held});
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    wait_idle();

    // Back-to-back reads: one IDLE cycle between transfers.
    send(1'b0, 2'd2, 10'h3FC, 8'h00);
    a0 = acc_cyc;
    send(1'b0, 2'd1, 10'h010, 8'h00);
    chk("b2b_gap", acc_cyc - a0, 32'd10);
    wait_idle();

    // Reset during bit 3 of a write to bank 3 at 0x100.
    send(1'b1, 2'd3, 10'h100, 8'hFF);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_addr == 10'h103) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("abort_reach_bit3", {31'd0, ok}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_strobes", {30'd0, mem_read_rq, mem_write_rq}, 32'd0);
    chk("abort_addr",    {22'd0, mem_addr}, 32'd0);
    chk("abort_sel",     {30'd0, mem_sel}, 32'd0);
    chk("abort_busy",    {31'd0, busy}, 32'd0);
    chk("abort_rsp",     {23'd0, rsp_valid, rsp_data}, 32'd0);
`ifdef MEM_SEQ_WRITE_ACK_EN
    void'(exp_q.pop_back());
`endif
    for (int i = 4; i < 8; i++) ref_mem[3][10'h100 + 10'(i)] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    send(1'b0, 2'd3, 10'h100, 8'h00);
    wait_idle();
    chk("abort_partial", {24'd0, ref_word(2'd3, 10'h100)}, 32'h00F);

    // Write 0x3C: response only when write acknowledge is built in.
    send(1'b1, 2'd0, 10'h200, 8'h3C);
    repeat (9) @(negedge clk);
`ifdef MEM_SEQ_WRITE_ACK_EN
    chk("wack_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wack_data",  {24'd0, rsp_data}, 32'h03C);
`else
    chk("wnoack_state", {29'd0, busy, req_ready, rsp_valid}, 32'b010);
`endif
    wait_idle();

    // Random traffic; monitor checks strobe exclusivity every cycle.
    for (int n = 0; n < 16; n++) begin
      rsp_ready = 1'($urandom_range(0, 3) != 0);
      send(1'($urandom), 2'($urandom), 10'($urandom), 8'($urandom));
      rsp_ready = 1'b1;
      wait_idle();
    end

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
